dcache_responder: RTL
=====================

Name: dcache_responder

Overview:
- Direct-mapped, write-back data cache that serves the pipeline's data-side requests on the datapath/cache interface: dmemREN, dmemWEN, dmemaddr, dmemstore and halt in; dhit and dmemload out.
- Issues word-wide reads and writes to the memory controller on misses, write-backs and the halt flush.
- Sits between datapath and memory arbiter.
- On halt, writes back every dirty line, then asserts flushed.

Parameters:
SETS, 8, number of cache lines; power of two, at least 2; IDX_W = log2(SETS).
HIT_CNT_ADDR, 32'h3100, memory word address written with the hit count (optional feature only).

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request
dmemaddr  in  32  datapath byte address; [1:0] ignored
dmemstore  in  32  datapath write data
halt  in  1  datapath halted; starts the flush
dhit  out  1  request serviced this cycle
dmemload  out  32  read data, valid when dhit=1
flushed  out  1  flush complete; sticky until reset
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data
dwait  in  1  memory busy; a transfer completes on the edge where dwait=0 with dREN or dWEN high
dload  in  32  memory read data

Behaviour:
- Address split: blk = addr[2]; idx = addr[2+IDX_W:3]; tag = addr[31:3+IDX_W].
- Line storage: valid, dirty, tag, word0, word1.
- Reset: all valid/dirty = 0; state IDLE; dhit, dREN, dWEN, flushed = 0; daddr, dstore, dmemload = 0. Reset asserted mid-refill or mid-flush aborts immediately; there is no partial write to the line.
- hit = valid[idx] && tag match. dhit is combinational, only in IDLE, only when (dmemREN|dmemWEN) && hit && !halt.
- Read hit: dmemload = selected word in the same cycle; zero wait states.
- Write hit: word and dirty=1 updated on the edge where dhit=1.
- If dmemREN and dmemWEN are both high, the write wins.
- With no request, dhit=0 and dmemload=0.

States:
- IDLE:
  - halt=1 -> FLUSH_CHK, with index counter = 0; halt has priority over a pending request.
  - Request miss with dirty line -> WB0.
  - Request miss with clean/invalid line -> FETCH0.
- WB0: dWEN=1, daddr={stored tag, idx, 3'b000}, dstore=word0. On dwait=0 -> WB1.
- WB1: same as WB0 for word1 at {.., 3'b100}. On dwait=0 -> FETCH0.
- FETCH0: dREN=1, daddr={req tag, idx, 3'b000}. On dwait=0, latch dload into word0 -> FETCH1.
- FETCH1: same as FETCH0 for word1. On dwait=0, write word1, tag, valid=1, dirty=0 -> IDLE.
  - The request then hits in IDLE the next cycle, so miss latency = 2 (clean) or 4 (dirty) memory transfers + 1 cycle.
- FLUSH_CHK:
  - dirty[cnt] -> FL_WB0.
  - Else if cnt == SETS-1 -> CNT_WR (feature on) or DONE.
  - Else cnt+1.
- FL_WB0/FL_WB1: write the two words as in WB0/WB1. After FL_WB1 completes, clear dirty[cnt] and return to FLUSH_CHK with cnt+1; if cnt == SETS-1, go to CNT_WR/DONE.
- DONE: flushed=1; dhit=0; no memory requests; terminal until reset.
- Request address or data changing during a miss: the refill completes for the originally latched idx/tag; IDLE then re-evaluates the current request.
- Memory outputs are 0 in every state that does not drive them. dREN and dWEN are never both 1.

Optional Feature:
- Macro DCACHE_HIT_COUNT_EN.
- Defined:
  - 32-bit wrapping hit counter, incremented on every cycle with dhit=1, cleared by reset.
  - Extra state CNT_WR after the flush: dWEN=1, daddr=HIT_CNT_ADDR, dstore=count; on dwait=0 -> DONE.
- Undefined: no counter and no CNT_WR; the flush goes directly to DONE.

Test Plan:
- Cold read 0x00000040: memory returns 0xAAAA0000/0xAAAA0001 with dwait=0 -> exactly two dREN transfers at 0x40 and 0x44; the next cycle gives dhit=1 and dmemload=0xAAAA0000. A read of 0x44 then hits with zero wait and returns 0xAAAA0001.
- Write hit 0x40 with 0xDEADBEEF, then read 0x40 -> dhit the same cycle, 0xDEADBEEF, no memory traffic.
- Conflict read 0x00000080 (same idx, line dirty), dwait held high 3 cycles per transfer -> dWEN at 0x40 (0xDEADBEEF) and 0x44, then dREN at 0x80 and 0x84. dhit stays low throughout and rises after FETCH1.
- Halt with lines 0 and 3 dirty (SETS=8) -> exactly four dWEN transfers, in index order; flushed=1 afterwards and stays 1.
- Reset asserted during FETCH1 -> all outputs 0 immediately; a re-read of the same address misses.
- DCACHE_HIT_COUNT_EN defined, 5 hit cycles then halt with no dirty lines -> a single dWEN at 0x3100 with dstore=5, then flushed=1.

Source files
------------

// File: rtl/dcache_responder_if.sv
// Datapath-side and memory-side signals of the data cache, bundled for port grouping.
// slave = the cache itself; master = the environment (datapath plus memory controller).
interface dcache_responder_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache, two words per line, with flush-on-halt.
// Define DCACHE_HIT_COUNT_EN to count hit cycles and write the count to HIT_CNT_ADDR after the flush.
//
// state     | meaning
// IDLE      | serve hits, detect misses and halt
// WB0/WB1   | write back victim word0/word1
// FETCH0/1  | refill word0/word1 for the latched idx/tag
// FLUSH_CHK | inspect dirty bit of line cnt
// FL_WB0/1  | write back line cnt during flush
// CNT_WR    | write hit count to memory (feature build only)
// DONE      | flushed, terminal until reset
module dcache_responder #(
  parameter int SETS = 8
`ifdef DCACHE_HIT_COUNT_EN
  , parameter logic [31:0] HIT_CNT_ADDR = 32'h3100
`endif
) (
  input logic CLK,
  input logic nRST,
  dcache_responder_if.slave dif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 29 - IDX_W;

  typedef enum logic [3:0] {
    S_IDLE, S_WB0, S_WB1, S_FETCH0, S_FETCH1,
    S_FLUSH_CHK, S_FL_WB0, S_FL_WB1, S_CNT_WR, S_DONE
  } state_t;

  state_t           r_state;
  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;
  logic [TAG_W-1:0] r_tag   [SETS];
  logic [31:0]      r_word0 [SETS];
  logic [31:0]      r_word1 [SETS];
  logic [IDX_W-1:0] r_lat_idx;
  logic [TAG_W-1:0] r_lat_tag;
  logic [IDX_W-1:0] r_cnt;
  logic [31:0]      r_fill_w0;
  logic             r_dren;
  logic             r_dwen;
  logic             r_flushed;
  logic [31:0]      r_daddr;
  logic [31:0]      r_dstore;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_blk;
  logic             w_req;
  logic             w_hit;
  logic             w_dhit;
  logic             w_wr_hit;
  logic             w_fill_done;
  logic             w_last;
  logic             w_unused_addr;

  assign w_idx         = dif.dmemaddr[2+IDX_W:3];
  assign w_tag         = dif.dmemaddr[31:3+IDX_W];
  assign w_blk         = dif.dmemaddr[2];
  assign w_unused_addr = ^dif.dmemaddr[1:0];
  assign w_req         = dif.dmemREN | dif.dmemWEN;
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_dhit        = (r_state == S_IDLE) && w_req && w_hit && !dif.halt;
  assign w_wr_hit      = w_dhit && dif.dmemWEN;
  assign w_fill_done   = (r_state == S_FETCH1) && !dif.dwait;
  assign w_last        = (r_cnt == IDX_W'(SETS - 1));

  assign dif.dhit     = w_dhit;
  assign dif.dmemload = w_dhit ? (w_blk ? r_word1[w_idx] : r_word0[w_idx]) : 32'h0;
  assign dif.flushed  = r_flushed;
  assign dif.dREN     = r_dren;
  assign dif.dWEN     = r_dwen;
  assign dif.daddr    = r_daddr;
  assign dif.dstore   = r_dstore;

`ifdef DCACHE_HIT_COUNT_EN
  logic [31:0] r_hit_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)       r_hit_cnt <= 32'h0;
    else if (w_dhit) r_hit_cnt <= r_hit_cnt + 32'h1;
  end
`endif

  // Line payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag[r_lat_idx]   <= r_lat_tag;
      r_word0[r_lat_idx] <= r_fill_w0;
      r_word1[r_lat_idx] <= dif.dload;
    end else if (w_wr_hit) begin
      if (w_blk) r_word1[w_idx] <= dif.dmemstore;
      else       r_word0[w_idx] <= dif.dmemstore;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_lat_idx <= '0;
      r_lat_tag <= '0;
      r_cnt     <= '0;
      r_fill_w0 <= 32'h0;
      r_dren    <= 1'b0;
      r_dwen    <= 1'b0;
      r_flushed <= 1'b0;
      r_daddr   <= 32'h0;
      r_dstore  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dif.halt) begin
            r_state <= S_FLUSH_CHK;
            r_cnt   <= '0;
          end else if (w_req && !w_hit) begin
            r_lat_idx <= w_idx;
            r_lat_tag <= w_tag;
            if (r_dirty[w_idx]) begin
              r_state  <= S_WB0;
              r_dwen   <= 1'b1;
              r_daddr  <= {r_tag[w_idx], w_idx, 3'b000};
              r_dstore <= r_word0[w_idx];
            end else begin
              r_state <= S_FETCH0;
              r_dren  <= 1'b1;
              r_daddr <= {w_tag, w_idx, 3'b000};
            end
          end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WB0: if (!dif.dwait) begin
          r_state    <= S_WB1;
          r_daddr[2] <= 1'b1;
          r_dstore   <= r_word1[r_lat_idx];
        end
        S_WB1: if (!dif.dwait) begin
          r_state  <= S_FETCH0;
          r_dwen   <= 1'b0;
          r_dren   <= 1'b1;
          r_daddr  <= {r_lat_tag, r_lat_idx, 3'b000};
          r_dstore <= 32'h0;
        end
        S_FETCH0: if (!dif.dwait) begin
          r_state    <= S_FETCH1;
          r_fill_w0  <= dif.dload;
          r_daddr[2] <= 1'b1;
        end
        S_FETCH1: if (!dif.dwait) begin
          r_state            <= S_IDLE;
          r_valid[r_lat_idx] <= 1'b1;
          r_dirty[r_lat_idx] <= 1'b0;
          r_dren             <= 1'b0;
          r_daddr            <= 32'h0;
        end
        S_FLUSH_CHK: begin
          if (r_dirty[r_cnt]) begin
            r_state  <= S_FL_WB0;
            r_dwen   <= 1'b1;
            r_daddr  <= {r_tag[r_cnt], r_cnt, 3'b000};
            r_dstore <= r_word0[r_cnt];
          end else if (w_last) begin
`ifdef DCACHE_HIT_COUNT_EN
            r_state  <= S_CNT_WR;
            r_dwen   <= 1'b1;
            r_daddr  <= HIT_CNT_ADDR;
            r_dstore <= r_hit_cnt;
`else
            r_state   <= S_DONE;
            r_flushed <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        S_FL_WB0: if (!dif.dwait) begin
          r_state    <= S_FL_WB1;
          r_daddr[2] <= 1'b1;
          r_dstore   <= r_word1[r_cnt];
        end
        S_FL_WB1: if (!dif.dwait) begin
          r_dirty[r_cnt] <= 1'b0;
          if (w_last) begin
`ifdef DCACHE_HIT_COUNT_EN
            r_state  <= S_CNT_WR;
            r_daddr  <= HIT_CNT_ADDR;
            r_dstore <= r_hit_cnt;
`else
            r_state   <= S_DONE;
            r_flushed <= 1'b1;
            r_dwen    <= 1'b0;
            r_daddr   <= 32'h0;
            r_dstore  <= 32'h0;
`endif
          end else begin
            r_state  <= S_FLUSH_CHK;
            r_cnt    <= r_cnt + IDX_W'(1);
            r_dwen   <= 1'b0;
            r_daddr  <= 32'h0;
            r_dstore <= 32'h0;
          end
        end
        S_CNT_WR: if (!dif.dwait) begin
          r_state   <= S_DONE;
          r_flushed <= 1'b1;
          r_dwen    <= 1'b0;
          r_daddr   <= 32'h0;
          r_dstore  <= 32'h0;
        end
        S_DONE: r_flushed <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
